vrf_wb_seq: RTL and testbench
=============================

// Module: vrf_wb_seq
// PURPOSE
//  Write-back sequencer: writer side of the VRF write port. Accepts one LANES-wide result vector per handshake from the
//  execution lanes. Buffers vectors in a small FIFO and serialises each into the bank-interleaved VRF write protocol:
//  a wr_req pulse, then LANES element cycles steered by wr_elem_cnt, closed by wr_ready. Sits between lane ALUs and VRF.
// PARAMETERS
//  DATA_WIDTH  32  element width in bits
//  REG_NUM     32  vector registers; ADDR_B = $clog2(REG_NUM)
//  LANES       4   elements per vector, = VRF banks; ELEM_B = $clog2(LANES), power of 2
//  FIFO_DEPTH  2   buffered result vectors, power of 2, >= 2
// PORTS
//  clk_i           in   1                 clock; all logic on posedge
//  rst_i           in   1                 asynchronous, active-high reset
//  res_valid_i     in   1                 result vector valid
//  res_ready_o     out  1                 FIFO not full; push = res_valid_i & res_ready_o
//  res_data_i      in   LANES*DATA_WIDTH  element k at [k*DATA_WIDTH +: DATA_WIDTH]
//  res_addr_i      in   ADDR_B            destination vector register
//  res_mask_i      in   LANES             per-element write enable
//  wr_req_o        out  1                 one-cycle write-transaction request to VRF
//  wr_en_o         out  1                 element write strobe
//  wr_ready_o      out  1                 last element of transaction; VRF returns to write idle
//  wr_addr_o       out  ADDR_B            destination register, stable for the whole transaction
//  wr_elem_cnt_o   out  ELEM_B            bank/element index
//  wdata_o         out  DATA_WIDTH        element data = head slice [wr_elem_cnt_o]
//  wb_busy_o       out  1                 FIFO non-empty or FSM not S_IDLE
//  wb_done_o       out  1                 one-cycle pulse per retired vector
// BEHAVIOUR
//  - Reset: FSM S_IDLE, FIFO empty, counter 0. All outputs 0 except res_ready_o = 1. Reset mid-transaction drops the
//    in-flight vector and all queued vectors, with no partial-completion pulse. The system resets the VRF together with this block.
//  - FSM: S_IDLE -> S_REQ if FIFO non-empty and head mask != 0.
//    S_IDLE with head mask == 0: pop, pulse wb_done_o next cycle, no VRF traffic.
//    S_REQ (1 cycle, wr_req_o = 1) -> S_WRITE with cnt = 0.
//    S_WRITE: wr_elem_cnt_o = cnt, wr_en_o = head mask[cnt], cnt++. At cnt == LANES-1: wr_ready_o = 1 and pop.
//    Then -> S_REQ if the next entry is valid with a nonzero mask, else -> S_IDLE.
//  - VRF write state is WR_EN one cycle after wr_req_o. wr_req_o is never asserted while wr_ready_o is high.
//    The VRF ignores requests in WR_EN, so S_REQ always follows the wr_ready_o cycle.
//  - Latency: push accepted at edge N -> S_REQ cycle N+2 -> elements N+3..N+2+LANES -> wb_done_o at N+3+LANES.
//    Back-to-back throughput: LANES+1 cycles per vector.
//  - Masked elements still take one cycle with wr_en_o = 0. Element order is always 0..LANES-1.
//  - res_ready_o = !full, from registered occupancy only. No combinational path from the pop.
//    Push and pop in the same cycle when not full: occupancy unchanged.
//  - wr_addr_o, wdata_o and wr_elem_cnt_o come from the FIFO head and cnt. They are 0 outside S_REQ/S_WRITE.
//  - wb_done_o is registered, the cycle after wr_ready_o. The counter wraps at LANES-1 with no overflow state.
// STRUCTURE
//  vrf_pkg: ADDR_B/ELEM_B helper functions; wb_state_t enum {S_IDLE,S_REQ,S_WRITE}; wb_entry_t struct {data,addr,mask}.
//  Sub-module vrf_wb_fifo: synchronous FIFO of wb_entry_t with ptr wrap, full/empty, head read.
//  The top holds the FSM, the element counter and the output muxing.
// TESTING (LANES=4, DATA_WIDTH=32, FIFO_DEPTH=2)
//  1 Assert rst_i for 3 cycles -> all VRF-side outputs 0, res_ready_o=1, wb_busy_o=0.
//  2 Push addr=5, data={0xD3,0xD2,0xD1,0xC0}, mask=4'hF at edge 0 -> wr_req_o at cycle 2.
//    Cycles 3..6: wr_elem_cnt_o 0..3, wdata_o 0xC0,0xD1,0xD2,0xD3, wr_en_o=1, wr_addr_o=5.
//    wr_ready_o at cycle 6, wb_done_o at cycle 7.
//  3 Mask 4'b0101 -> 4 element cycles; wr_en_o=1 only at cnt 0 and 2.
//  4 Push 3 vectors back-to-back -> res_ready_o low while 2 are queued.
//    Each next wr_req_o comes the cycle after the prior wr_ready_o. 15 cycles from the first wr_req_o to the last wr_ready_o.
//  5 Mask 4'h0 -> no wr_req_o, entry popped, wb_done_o pulses once 2 cycles after the push.
//  6 rst_i high during S_WRITE at cnt=2 -> outputs 0 in the same cycle, FIFO empty. No wb_done_o after release.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared types and sizing helpers for the VRF write-back path.
// Default configuration: 4 lanes of 32-bit elements, 32 registers.
package vrf_pkg;

  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int elem_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int LANE_N = 4;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = addr_bits(REG_N);
  localparam int ELEM_W = elem_bits(LANE_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WRITE
  } wb_state_t;

  typedef struct packed {
    logic [LANE_N*DATA_W-1:0] data;
    logic [ADDR_W-1:0]        addr;
    logic [LANE_N-1:0]        mask;
  } wb_entry_t;

endpackage

// File: rtl/vrf_wb_fifo.sv
// Result-vector buffer for the write-back sequencer.
// Exposes the head and the entry behind it for chained transactions.
module vrf_wb_fifo
  import vrf_pkg::*;
#(
  parameter int DEPTH_P = DEPTH
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  wb_entry_t din_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output wb_entry_t nxt_o,
  output logic      nxt_valid_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = $clog2(DEPTH_P);

  wb_entry_t       mem [DEPTH_P];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [PW:0]     occ;
  logic [PW-1:0]   rd_nxt;

  assign occ         = wr_ptr - rd_ptr;
  assign full_o      = (occ == (PW+1)'(DEPTH_P));
  assign empty_o     = (occ == '0);
  assign nxt_valid_o = (occ > (PW+1)'(1));
  assign rd_nxt      = rd_ptr[PW-1:0] + 1'b1;
  assign head_o      = mem[rd_ptr[PW-1:0]];
  assign nxt_o       = mem[rd_nxt];

  // Pointers carry a wrap bit so full and empty differ.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_i && !empty_o)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; contents are qualified by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o)
      mem[wr_ptr[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/vrf_wb_seq.sv
// Write-back sequencer: buffers lane result vectors and
// serialises each one into the banked VRF write protocol.
module vrf_wb_seq
  import vrf_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_W,
  parameter  int REG_NUM    = REG_N,
  parameter  int LANES      = LANE_N,
  parameter  int FIFO_DEPTH = DEPTH,
  localparam int ADDR_B     = addr_bits(REG_NUM),
  localparam int ELEM_B     = elem_bits(LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        res_valid_i,
  output logic                        res_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0] res_data_i,
  input  logic [ADDR_B-1:0]           res_addr_i,
  input  logic [LANES-1:0]            res_mask_i,
  output logic                        wr_req_o,
  output logic                        wr_en_o,
  output logic                        wr_ready_o,
  output logic [ADDR_B-1:0]           wr_addr_o,
  output logic [ELEM_B-1:0]           wr_elem_cnt_o,
  output logic [DATA_WIDTH-1:0]       wdata_o,
  output logic                        wb_busy_o,
  output logic                        wb_done_o
);

  localparam logic [ELEM_B-1:0] LAST = ELEM_B'(LANES - 1);

  wb_state_t         state;
  wb_state_t         state_nxt;
  logic [ELEM_B-1:0] cnt;
  logic [ELEM_B-1:0] cnt_nxt;
  logic              done_q;
  logic              full;
  logic              empty;
  logic              nxt_valid;
  logic              push;
  logic              pop;
  logic              act;
  wb_entry_t         in_entry;
  wb_entry_t         head;
  wb_entry_t         nxt;

  assign in_entry = '{
    data: res_data_i,
    addr: res_addr_i,
    mask: res_mask_i
  };

  assign push        = res_valid_i && !full;
  assign res_ready_o = !full;

  vrf_wb_fifo #(
    .DEPTH_P (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .din_i       (in_entry),
    .pop_i       (pop),
    .head_o      (head),
    .nxt_o       (nxt),
    .nxt_valid_o (nxt_valid),
    .full_o      (full),
    .empty_o     (empty)
  );

  // State, element counter and retire pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= pop;
    end
  end

  // Next state; an all-masked head retires without VRF traffic,
  // and a ready cycle chains straight into the next request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          if (head.mask != '0)
            state_nxt = S_REQ;
          else
            pop = 1'b1;
        end
      end
      S_REQ: begin
        state_nxt = S_WRITE;
        cnt_nxt   = '0;
      end
      S_WRITE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          pop = 1'b1;
          if (nxt_valid && nxt.mask != '0)
            state_nxt = S_REQ;
          else
            state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // VRF-side outputs, forced to zero outside a transaction.
  always_comb begin
    act           = (state == S_REQ) || (state == S_WRITE);
    wr_req_o      = (state == S_REQ);
    wr_en_o       = 1'b0;
    wr_ready_o    = 1'b0;
    wr_addr_o     = '0;
    wr_elem_cnt_o = '0;
    wdata_o       = '0;
    if (state == S_WRITE) begin
      wr_en_o    = head.mask[cnt];
      wr_ready_o = (cnt == LAST);
    end
    if (act) begin
      wr_addr_o     = head.addr;
      wr_elem_cnt_o = cnt;
      wdata_o       = head.data[cnt*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign wb_busy_o = !empty || (state != S_IDLE);
  assign wb_done_o = done_q;

endmodule

// File: tb/tb_vrf_wb_seq.sv
// Scoreboard bench for the VRF write-back sequencer.
// Stimulus enqueues expected vectors; a monitor checks traffic.
module tb_vrf_wb_seq;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int AB = 5;
  localparam int EB = 2;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              res_valid_i = 1'b0;
  logic              res_ready_o;
  logic [LN*DW-1:0]  res_data_i = '0;
  logic [AB-1:0]     res_addr_i = '0;
  logic [LN-1:0]     res_mask_i = '0;
  logic              wr_req_o;
  logic              wr_en_o;
  logic              wr_ready_o;
  logic [AB-1:0]     wr_addr_o;
  logic [EB-1:0]     wr_elem_cnt_o;
  logic [DW-1:0]     wdata_o;
  logic              wb_busy_o;
  logic              wb_done_o;

  vrf_wb_seq dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .res_data_i    (res_data_i),
    .res_addr_i    (res_addr_i),
    .res_mask_i    (res_mask_i),
    .wr_req_o      (wr_req_o),
    .wr_en_o       (wr_en_o),
    .wr_ready_o    (wr_ready_o),
    .wr_addr_o     (wr_addr_o),
    .wr_elem_cnt_o (wr_elem_cnt_o),
    .wdata_o       (wdata_o),
    .wb_busy_o     (wb_busy_o),
    .wb_done_o     (wb_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AB-1:0]    addr;
    logic [LN*DW-1:0] data;
    logic [LN-1:0]    mask;
  } vec_t;

  vec_t exp_q[$];
  vec_t cur;
  int   req_q[$];
  int   rdy_q[$];
  int   done_q[$];
  int   edge_n = 0;
  int   push_edge = 0;
  int   done_expect = 0;
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  bit   in_txn = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare every VRF cycle against the popped vector.
  always @(negedge clk) begin
    if (wr_req_o) begin
      req_q.push_back(edge_n);
      chk("req_with_ready", wr_ready_o, 0);
      chk("req_in_txn", in_txn, 0);
      chk("req_cnt", wr_elem_cnt_o, 0);
      if (exp_q.size() == 0) begin
        fail("req_unexpected");
      end else begin
        cur = exp_q.pop_front();
        chk("req_addr", wr_addr_o, cur.addr);
        in_txn = 1;
        k = 0;
      end
    end else if (in_txn) begin
      chk("elem_cnt", wr_elem_cnt_o, k);
      chk("wdata", wdata_o, cur.data[k*DW +: DW]);
      chk("wr_en", wr_en_o, cur.mask[k]);
      chk("wr_addr", wr_addr_o, cur.addr);
      chk("wr_ready", wr_ready_o, (k == LN-1));
      if (wr_ready_o) rdy_q.push_back(edge_n);
      k++;
      if (k == LN) begin
        in_txn = 0;
        done_expect++;
      end
    end else begin
      chk("stray_wr_en", wr_en_o, 0);
      chk("stray_wr_ready", wr_ready_o, 0);
    end
    if (wb_done_o) begin
      done_q.push_back(edge_n);
      if (done_expect > 0) begin
        checks++;
        done_expect--;
      end else begin
        fail("done_unexpected");
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, wr_req_o, 0);
    chk({tag, "_en"}, wr_en_o, 0);
    chk({tag, "_rdy"}, wr_ready_o, 0);
    chk({tag, "_addr"}, wr_addr_o, 0);
    chk({tag, "_cnt"}, wr_elem_cnt_o, 0);
    chk({tag, "_wdata"}, wdata_o, 0);
    chk({tag, "_done"}, wb_done_o, 0);
    chk({tag, "_busy"}, wb_busy_o, 0);
    chk({tag, "_resrdy"}, res_ready_o, 1);
  endtask

  task automatic push(input logic [AB-1:0] a,
                      input logic [LN*DW-1:0] d,
                      input logic [LN-1:0] m);
    bit   acc = 0;
    vec_t v;
    @(negedge clk);
    res_valid_i = 1;
    res_addr_i  = a;
    res_data_i  = d;
    res_mask_i  = m;
    for (int t = 0; t < 100 && !acc; t++) begin
      if (t > 0) @(negedge clk);
      acc = res_ready_o;
      @(posedge clk);
      #1;
    end
    res_valid_i = 0;
    if (!acc) begin
      fail("push_timeout");
    end else begin
      push_edge = edge_n;
      v.addr = a;
      v.data = d;
      v.mask = m;
      if (m != '0) exp_q.push_back(v);
      else done_expect++;
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      #1;
      ok = !wb_busy_o && !in_txn && (done_expect == 0);
    end
    if (!ok) fail("idle_timeout");
  endtask

  task automatic clear_log();
    req_q.delete();
    rdy_q.delete();
    done_q.delete();
  endtask

  initial begin
    int pe;
    bit hit;

    // 1: reset state
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_i = 0;

    // 2: full mask, latency
    clear_log();
    push(5, {32'hD3, 32'hD2, 32'hD1, 32'hC0}, 4'hF);
    pe = push_edge;
    wait_idle();
    chk("t2_reqs", req_q.size(), 1);
    chk("t2_rdys", rdy_q.size(), 1);
    chk("t2_dones", done_q.size(), 1);
    if (req_q.size() == 1) chk("t2_req_cyc", req_q[0] - pe, 1);
    if (rdy_q.size() == 1) chk("t2_rdy_cyc", rdy_q[0] - pe, 5);
    if (done_q.size() == 1) chk("t2_done_cyc", done_q[0] - pe, 6);

    // 3: sparse mask
    clear_log();
    push(9, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b0101);
    wait_idle();
    chk("t3_reqs", req_q.size(), 1);
    chk("t3_dones", done_q.size(), 1);

    // 4: back-to-back vectors
    clear_log();
    push(1, {32'h13, 32'h12, 32'h11, 32'h10}, 4'hF);
    push(2, {32'h23, 32'h22, 32'h21, 32'h20}, 4'h8);
    chk("t4_full", res_ready_o, 0);
    push(3, {32'h33, 32'h32, 32'h31, 32'h30}, 4'h6);
    wait_idle();
    chk("t4_reqs", req_q.size(), 3);
    chk("t4_rdys", rdy_q.size(), 3);
    chk("t4_dones", done_q.size(), 3);
    if (req_q.size() == 3 && rdy_q.size() == 3) begin
      chk("t4_gap0", req_q[1] - rdy_q[0], 1);
      chk("t4_gap1", req_q[2] - rdy_q[1], 1);
      chk("t4_span", rdy_q[2] - req_q[0], 14);
    end

    // 5: all-masked vector
    clear_log();
    push(7, {32'h73, 32'h72, 32'h71, 32'h70}, 4'h0);
    pe = push_edge;
    wait_idle();
    chk("t5_reqs", req_q.size(), 0);
    chk("t5_dones", done_q.size(), 1);
    if (done_q.size() == 1) chk("t5_done_cyc", done_q[0] - pe, 1);

    // 6: reset during a transaction
    clear_log();
    push(4, {32'h43, 32'h42, 32'h41, 32'h40}, 4'hF);
    push(6, {32'h63, 32'h62, 32'h61, 32'h60}, 4'hF);
    hit = 0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      hit = wr_en_o && (wr_elem_cnt_o == 2);
    end
    if (!hit) fail("t6_no_cnt2");
    #2;
    rst_i = 1;
    #1;
    chk_idle("t6_rst");
    exp_q.delete();
    in_txn = 0;
    done_expect = 0;
    clear_log();
    repeat (2) @(negedge clk);
    rst_i = 0;
    repeat (12) @(negedge clk);
    #1;
    chk("t6_reqs", req_q.size(), 0);
    chk("t6_rdys", rdy_q.size(), 0);
    chk("t6_dones", done_q.size(), 0);
    chk_idle("t6_after");

    chk("left_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
